// File: rtl/jtag_cmd_fifo.sv
// rtl/jtag_cmd_fifo.sv - first-word-fall-through FIFO for vJTAG command words
// NIL/zero opcodes are dropped at the input; refused pushes are counted.
module jtag_cmd_fifo #(
    parameter int             DEPTH  = 8,
    parameter int             OPW    = 4,
    parameter int             DATAW  = 32,
    parameter logic [OPW-1:0] NIL_OP = {OPW{1'b1}}
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     flush,
    input  logic                     push_valid,
    input  logic [OPW-1:0]           push_opcode,
    input  logic [DATAW-1:0]         push_data,
    output logic                     push_ready,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [OPW-1:0]           pop_opcode,
    output logic [DATAW-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               overflow_count,
    output logic [31:0]              accepted_count
);

    localparam int             AW       = $clog2(DEPTH);
    localparam int             CW       = AW + 1;
    localparam int             WW       = OPW + DATAW;
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    logic [WW-1:0] mem_q [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    ovf_cnt_q, ovf_cnt_d;
    logic [31:0]   acc_cnt_q, acc_cnt_d;

    logic          op_ok;
    logic          push_fire;
    logic          pop_fire;
    logic          refused;
    logic          mem_we;
    logic [WW-1:0] head_word;

    always_comb begin
        op_ok      = (push_opcode != NIL_OP) && (push_opcode != '0);
        push_ready = (count_q < FULL_CNT);
        pop_valid  = (count_q != '0);
        push_fire  = push_valid & push_ready & op_ok;
        pop_fire   = pop_valid & pop_ready;
        refused    = push_valid & ~push_ready & op_ok;
        mem_we     = push_fire & ~flush;
        head_word  = mem_q[rd_ptr_q];
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        ovf_cnt_d  = ovf_cnt_q;
        acc_cnt_d  = acc_cnt_q;
        if (flush) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            ovf_cnt_d  = '0;
            acc_cnt_d  = '0;
        end else begin
            if (push_fire) begin
                wr_ptr_d  = wr_ptr_q + 1'b1;
                acc_cnt_d = acc_cnt_q + 32'd1;
            end
            if (pop_fire) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (refused) begin
                overflow_d = 1'b1;
                if (ovf_cnt_q != 8'hFF) begin
                    ovf_cnt_d = ovf_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            ovf_cnt_q  <= '0;
            acc_cnt_q  <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            ovf_cnt_q  <= ovf_cnt_d;
            acc_cnt_q  <= acc_cnt_d;
        end
    end

    // Storage is deliberately left out of reset; count gates its visibility.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= {push_opcode, push_data};
        end
    end

    assign pop_opcode     = head_word[WW-1:DATAW];
    assign pop_data       = head_word[DATAW-1:0];
    assign count          = count_q;
    assign overflow       = overflow_q;
    assign overflow_count = ovf_cnt_q;
    assign accepted_count = acc_cnt_q;

endmodule

// File: tb/tb_jtag_cmd_fifo.sv
// tb/tb_jtag_cmd_fifo.sv - randomized scoreboard bench for jtag_cmd_fifo
module tb_jtag_cmd_fifo;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        areset;
    logic        flush;
    logic        push_valid;
    logic [3:0]  push_opcode;
    logic [31:0] push_data;
    logic        push_ready;
    logic        pop_valid;
    logic        pop_ready;
    logic [3:0]  pop_opcode;
    logic [31:0] pop_data;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  overflow_count;
    logic [31:0] accepted_count;

    jtag_cmd_fifo dut (
        .clk            (clk),
        .areset         (areset),
        .flush          (flush),
        .push_valid     (push_valid),
        .push_opcode    (push_opcode),
        .push_data      (push_data),
        .push_ready     (push_ready),
        .pop_valid      (pop_valid),
        .pop_ready      (pop_ready),
        .pop_opcode     (pop_opcode),
        .pop_data       (pop_data),
        .count          (count),
        .overflow       (overflow),
        .overflow_count (overflow_count),
        .accepted_count (accepted_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [35:0] exp_q [$];
    int          m_count;
    logic        m_ovf;
    int          m_ovf_cnt;
    logic [31:0] m_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_count   = 0;
        m_ovf     = 1'b0;
        m_ovf_cnt = 0;
        m_acc     = '0;
    endtask

    task automatic check_state();
        chk("count",          32'(count),          32'(m_count));
        chk("push_ready",     32'(push_ready),     32'(m_count < DEPTH));
        chk("pop_valid",      32'(pop_valid),      32'(m_count != 0));
        chk("overflow",       32'(overflow),       32'(m_ovf));
        chk("overflow_count", 32'(overflow_count), 32'(m_ovf_cnt));
        chk("accepted_count", accepted_count,      m_acc);
    endtask

    // One clock: drive inputs, advance the model for the coming edge, check after it.
    task automatic step(input logic pv, input logic [3:0] op, input logic [31:0] d,
                        input logic pr, input logic fl);
        logic ok;
        logic acc;
        logic pop;
        push_valid  = pv;
        push_opcode = op;
        push_data   = d;
        pop_ready   = pr;
        flush       = fl;
        ok = (op != 4'h0) && (op != 4'hF);
        if (fl) begin
            model_clear();
        end else begin
            acc = pv && ok && (m_count < DEPTH);
            pop = pr && (m_count > 0);
            if (pv && ok && m_count == DEPTH) begin
                m_ovf = 1'b1;
                if (m_ovf_cnt < 255) m_ovf_cnt++;
            end
            if (acc) begin
                exp_q.push_back({op, d});
                m_acc = m_acc + 32'd1;
            end
            m_count = m_count + int'(acc) - int'(pop);
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle(input int n, input logic pr);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, pr, 1'b0);
    endtask

    // Monitor: a head word is consumed on the edge following this sample.
    always @(negedge clk) begin
        if (!areset && !flush && pop_valid && pop_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL pop_underrun: got 0x%0h_%0h expected no entry", pop_opcode, pop_data);
            end else begin
                logic [35:0] w;
                w = exp_q.pop_front();
                if ({pop_opcode, pop_data} !== w) begin
                    n_errors++;
                    $display("FAIL pop_word: got 0x%0h_%08h expected 0x%0h_%08h",
                             pop_opcode, pop_data, w[35:32], w[31:0]);
                end
            end
        end
    end

    initial begin
        areset      = 1'b1;
        flush       = 1'b0;
        push_valid  = 1'b0;
        push_opcode = 4'h0;
        push_data   = 32'h0;
        pop_ready   = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        areset = 1'b0;
        check_state();
        idle(2, 1'b0);

        // ordered push then pop
        step(1'b1, 4'h2, 32'h11, 1'b0, 1'b0);
        step(1'b1, 4'h3, 32'h22, 1'b0, 1'b0);
        step(1'b1, 4'h7, 32'h33, 1'b0, 1'b0);
        idle(3, 1'b1);

        // filtered opcodes
        step(1'b1, 4'hF, 32'h55, 1'b0, 1'b0);
        step(1'b1, 4'h0, 32'h66, 1'b0, 1'b0);
        step(1'b1, 4'h4, 32'hAA, 1'b0, 1'b0);
        idle(1, 1'b1);

        // fill, overflow, filtered while full, push+pop while full
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 4'($urandom_range(1, 14)), $urandom, 1'b0, 1'b0);
        step(1'b1, 4'h7, 32'hDEAD0001, 1'b0, 1'b0);
        step(1'b1, 4'h7, 32'hDEAD0002, 1'b0, 1'b0);
        step(1'b1, 4'hF, 32'hDEAD0003, 1'b0, 1'b0);
        step(1'b1, 4'h0, 32'hDEAD0004, 1'b0, 1'b0);
        step(1'b1, 4'h5, 32'hDEAD0005, 1'b1, 1'b0);
        idle(DEPTH, 1'b1);
        // empty with simultaneous push and pop
        step(1'b1, 4'h9, 32'h99, 1'b1, 1'b0);
        idle(2, 1'b1);

        // random traffic across pointer wrap
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom,
                 $urandom_range(0, 1) == 1, 1'b0);
        idle(DEPTH + 1, 1'b1);

        // overflow saturation
        for (int i = 0; i < DEPTH; i++) step(1'b1, 4'h1, 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) step(1'b1, 4'h2, 32'hBAD, 1'b0, 1'b0);

        // flush with queued entries and simultaneous push/pop
        step(1'b1, 4'h3, 32'h12345678, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 4'h6, 32'h500 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 4'h3, 32'h87654321, 1'b1, 1'b1);
        idle(1, 1'b0);
        step(1'b1, 4'hC, 32'hC0FFEE, 1'b0, 1'b0);
        idle(2, 1'b1);

        // async reset mid-burst
        for (int i = 0; i < 4; i++) step(1'b1, 4'hA, 32'hA00 + 32'(i), 1'b0, 1'b0);
        push_valid = 1'b1;
        push_opcode = 4'hB;
        push_data = 32'hB00;
        #2;
        areset = 1'b1;
        model_clear();
        #1;
        check_state();
        push_valid = 1'b0;
        @(posedge clk);
        #1;
        areset = 1'b0;
        check_state();
        step(1'b1, 4'hD, 32'hD00D, 1'b0, 1'b0);
        idle(DEPTH + 1, 1'b1);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
